fwd_hazard_scoreboard: RTL and testbench
========================================

# fwd_hazard_scoreboard

Parametrised forwarding and interlock unit for the pipelined RV32 core, the successor to the fixed two-stage EX forwarding logic. It selects, per EX source operand, the youngest ready producer among NUM_FWD pipeline stages or a long-latency completion bus. A registered per-register scoreboard tracks outstanding multi-cycle writes (MUL/DIV, future FPU), and the unit raises a single stall for load-use, RAW-on-pending, WAW-on-pending and long-op-capacity hazards. It sits between ID/EX control and the operand muxes and also feeds the pipeline stall/bubble logic.

## Interface
- NUM_SRC, 2: source operands checked per instruction.
- NUM_FWD, 2: forwarding stages; index 0 is the youngest (EX/MEM), higher indices are older.
- NREG, 32: architectural registers; x0 is hardwired zero.
- LONG_DEPTH, 4: maximum outstanding long-latency ops.
- clk  in  1  core clock. One clock domain; reset is asynchronous and active-low.
- rst_n  in  1  asynchronous active-low reset.
- src_addr_i  in  NUM_SRC×5  source register index of the instruction in EX.
- src_used_i  in  NUM_SRC  the operand is actually read.
- stg_rd_i  in  NUM_FWD×5  destination index held in each stage.
- stg_we_i  in  NUM_FWD  the stage will write rd.
- stg_rdy_i  in  NUM_FWD  the stage's result is already available (0 for a load still in MEM).
- issue_valid_i  in  1  the EX instruction requests to advance.
- issue_rd_i  in  5  destination of the issuing instruction.
- issue_we_i  in  1  the issuing instruction writes rd.
- issue_long_i  in  1  the issuing instruction is long-latency.
- long_done_i  in  1  a long op is presenting its result this cycle.
- long_rd_i  in  5  destination of the completing long op.
- flush_i  in  1  kill the issuing instruction.
- fwd_sel_o  out  NUM_SRC×SEL_W  operand source: 0 = regfile; k in 1..NUM_FWD = stage k-1; NUM_FWD+1 = long bus.
- stall_o  out  1  hold EX and upstream, insert a bubble.
- pend_o  out  NREG  scoreboard, one bit per register.
- long_cnt_o  out  $clog2(LONG_DEPTH+1)  number of outstanding long ops.
- stall_cycles_o  out  32  saturating performance counter of stalled cycles.
- err_o  out  1  sticky flag: a completion arrived with nothing outstanding.

## Operation
- A source is "live" when src_used_i=1 and src_addr_i≠0. A non-live source gets fwd_sel=0 and never stalls.
- Match priority for a live source s:
  - A long_done_i hit on s wins: sel=NUM_FWD+1.
  - Otherwise the lowest stage k with stg_we_i[k] and stg_rd_i[k]==s.
    - If stg_rdy_i[k]=1: sel=k+1.
    - If stg_rdy_i[k]=0: load-use stall, sel don't-care.
    - An older ready match never overrides a younger unready one.
  - Otherwise, if pend[s]=1: RAW stall.
  - Otherwise sel=0.
- WAW stall: issue_we_i, issue_rd_i≠0 and pend[issue_rd_i]=1, unless long_done_i clears that register this cycle.
- Capacity stall: issue_long_i and long_cnt==LONG_DEPTH, unless long_done_i fires this cycle.
- stall_o is the OR of all hazards and is gated by issue_valid_i. stall_o is 0 when issue_valid_i=0.
- An issue is accepted when issue_valid_i & ~stall_o & ~flush_i.
- Scoreboard set: accepted & issue_long_i & issue_we_i & rd≠0 sets pend[rd].
- Scoreboard clear: long_done_i clears pend[long_rd_i]. A set and a clear of the same register in one cycle leaves it set.
- long_cnt:
  - +1 on an accepted long issue; −1 on long_done_i; unchanged when both occur.
  - long_done_i with long_cnt==0 is ignored, the count stays 0, and err_o sets.
- flush_i does not clear the scoreboard. Already-issued long ops always complete.
- stall_cycles_o increments on every cycle with stall_o=1 and saturates at 0xFFFF_FFFF.

## Timing
- fwd_sel_o and stall_o are combinational from the inputs and the registered pend/long_cnt. Zero-cycle latency.
- pend_o, long_cnt_o, stall_cycles_o and err_o update on the rising clk edge. A newly set pend bit first affects stall_o the next cycle.
- Reset values: pend_o=0, long_cnt_o=0, stall_cycles_o=0, err_o=0. With zero inputs the combinational outputs give fwd_sel_o=0 and stall_o=0.
- Reset asserted mid-operation clears all state immediately. In-flight long completions after reset are counted as errors.

## Structure
- Put SEL_W = $clog2(NUM_FWD+2), the fwd-select encoding constants (FWD_RF=0, FWD_LONG=NUM_FWD+1) and the hazard-cause enum (HZ_NONE, HZ_LOADUSE, HZ_RAW, HZ_WAW, HZ_CAP) in rv32_pkg.
- One sub-module, fwd_src_match, is instantiated NUM_SRC times. It does the combinational priority match per operand and returns sel plus its hazard cause.
- The top level holds the scoreboard, the counter, the performance counter and the stall OR.

## Test plan
- Stage0 rd=5 ready, stage1 rd=5 ready, src0=5 → fwd_sel[0]=1, stall_o=0.
- Stage0 rd=7 we=1 rdy=0 (load), src1=7 → stall_o=1. The next cycle, with it in stage1 ready → sel=2, stall_o=0.
- Long issue rd=9 accepted; the next cycle src0=9 → stall_o=1 until long_done_i with long_rd_i=9, where sel=NUM_FWD+1 and stall_o=0. pend_o[9] is 0 afterwards.
- Four long issues to rd 1..4 → long_cnt_o=4. A fifth stalls, and is accepted in the cycle long_done_i fires, leaving long_cnt_o at 4.
- Issue with rd=0, and src=0 matching stage rd=0 → no pend bit set, sel=0, no stall.
- long_done_i with long_cnt_o=0 → err_o=1 and sticky. After rst_n low, all outputs return to 0.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared constants and types for the RV32 forwarding / interlock unit.
package rv32_pkg;

  localparam int NUM_FWD_DEF = 2;
  localparam int SEL_W       = $clog2(NUM_FWD_DEF + 2);
  localparam int FWD_RF      = 0;
  localparam int FWD_LONG    = NUM_FWD_DEF + 1;

  typedef enum logic [2:0] {
    HZ_NONE,
    HZ_LOADUSE,
    HZ_RAW,
    HZ_WAW,
    HZ_CAP
  } hz_cause_t;

  // Select width and long-bus code for an arbitrary number of forwarding stages.
  function automatic int sel_width(input int nfwd);
    return $clog2(nfwd + 2);
  endfunction

  function automatic int long_code(input int nfwd);
    return nfwd + 1;
  endfunction

endpackage

// File: rtl/fwd_hazard_scoreboard_if.sv
// Bundle of ID/EX-side signals between the pipeline control and the hazard unit.
interface fwd_hazard_scoreboard_if
  import rv32_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int NUM_FWD    = NUM_FWD_DEF,
  parameter int NREG       = 32,
  parameter int LONG_DEPTH = 4
);

  localparam int SW = sel_width(NUM_FWD);
  localparam int CW = $clog2(LONG_DEPTH + 1);

  logic [NUM_SRC-1:0][4:0]    src_addr_i;
  logic [NUM_SRC-1:0]         src_used_i;
  logic [NUM_FWD-1:0][4:0]    stg_rd_i;
  logic [NUM_FWD-1:0]         stg_we_i;
  logic [NUM_FWD-1:0]         stg_rdy_i;
  logic                       issue_valid_i;
  logic [4:0]                 issue_rd_i;
  logic                       issue_we_i;
  logic                       issue_long_i;
  logic                       long_done_i;
  logic [4:0]                 long_rd_i;
  logic                       flush_i;
  logic [NUM_SRC-1:0][SW-1:0] fwd_sel_o;
  logic                       stall_o;
  logic [NREG-1:0]            pend_o;
  logic [CW-1:0]              long_cnt_o;
  logic [31:0]                stall_cycles_o;
  logic                       err_o;

  modport master (
    output src_addr_i, src_used_i, stg_rd_i, stg_we_i, stg_rdy_i,
           issue_valid_i, issue_rd_i, issue_we_i, issue_long_i,
           long_done_i, long_rd_i, flush_i,
    input  fwd_sel_o, stall_o, pend_o, long_cnt_o, stall_cycles_o, err_o
  );

  modport slave (
    input  src_addr_i, src_used_i, stg_rd_i, stg_we_i, stg_rdy_i,
           issue_valid_i, issue_rd_i, issue_we_i, issue_long_i,
           long_done_i, long_rd_i, flush_i,
    output fwd_sel_o, stall_o, pend_o, long_cnt_o, stall_cycles_o, err_o
  );

endinterface

// File: rtl/fwd_src_match.sv
// Per-operand priority match: long completion bus, then youngest matching stage,
// then the pending scoreboard bit.
module fwd_src_match
  import rv32_pkg::*;
#(
  parameter int NUM_FWD  = NUM_FWD_DEF,
  parameter int SEL_BITS = sel_width(NUM_FWD)
) (
  input  logic [4:0]              src_addr,
  input  logic                    src_used,
  input  logic [NUM_FWD-1:0][4:0] stg_rd,
  input  logic [NUM_FWD-1:0]      stg_we,
  input  logic [NUM_FWD-1:0]      stg_rdy,
  input  logic                    pend_hit,
  input  logic                    long_done,
  input  logic [4:0]              long_rd,
  output logic [SEL_BITS-1:0]     sel,
  output hz_cause_t               cause
);

  logic live;
  logic hit;

  assign live = src_used && (src_addr != 5'd0);

  // The first (youngest) stage match decides, even when it is not ready yet,
  // so an older ready copy can never hide a load that is still in flight.
  always_comb begin
    sel   = SEL_BITS'(FWD_RF);
    cause = HZ_NONE;
    hit   = 1'b0;
    if (live) begin
      if (long_done && (long_rd == src_addr)) begin
        sel = SEL_BITS'(long_code(NUM_FWD));
      end else begin
        for (int k = 0; k < NUM_FWD; k++) begin
          if (!hit && stg_we[k] && (stg_rd[k] == src_addr)) begin
            hit = 1'b1;
            if (stg_rdy[k]) begin
              sel = SEL_BITS'(k + 1);
            end else begin
              cause = HZ_LOADUSE;
            end
          end
        end
        if (!hit && pend_hit) begin
          cause = HZ_RAW;
        end
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding select, hazard stall and long-latency scoreboard for the EX stage.
module fwd_hazard_scoreboard
  import rv32_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int NUM_FWD    = NUM_FWD_DEF,
  parameter int NREG       = 32,
  parameter int LONG_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  fwd_hazard_scoreboard_if.slave  bus
);

  localparam int SW = sel_width(NUM_FWD);
  localparam int CW = $clog2(LONG_DEPTH + 1);

  logic [NREG-1:0] pend;
  logic [NREG-1:0] pend_next;
  logic [CW-1:0]   long_cnt;
  logic [31:0]     stall_cycles;
  logic            err;

  hz_cause_t       cause [NUM_SRC];
  logic [SW-1:0]   sel   [NUM_SRC];
  logic            src_hz;
  logic            waw_hz;
  logic            cap_hz;
  logic            stall;
  logic            accept;
  logic            long_inc;
  logic            long_dec;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    fwd_src_match #(
      .NUM_FWD  (NUM_FWD),
      .SEL_BITS (SW)
    ) u_match (
      .src_addr  (bus.src_addr_i[s]),
      .src_used  (bus.src_used_i[s]),
      .stg_rd    (bus.stg_rd_i),
      .stg_we    (bus.stg_we_i),
      .stg_rdy   (bus.stg_rdy_i),
      .pend_hit  (pend[bus.src_addr_i[s]]),
      .long_done (bus.long_done_i),
      .long_rd   (bus.long_rd_i),
      .sel       (sel[s]),
      .cause     (cause[s])
    );
    assign bus.fwd_sel_o[s] = sel[s];
  end

  always_comb begin
    src_hz = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (cause[s] != HZ_NONE) begin
        src_hz = 1'b1;
      end
    end
  end

  // A completion landing on the same register this cycle resolves WAW and
  // frees a slot for capacity, so neither needs to stall.
  assign waw_hz = bus.issue_we_i && (bus.issue_rd_i != 5'd0) && pend[bus.issue_rd_i]
                  && !(bus.long_done_i && (bus.long_rd_i == bus.issue_rd_i));
  assign cap_hz = bus.issue_long_i && (long_cnt == CW'(LONG_DEPTH)) && !bus.long_done_i;

  assign stall    = bus.issue_valid_i && (src_hz || waw_hz || cap_hz);
  assign accept   = bus.issue_valid_i && !stall && !bus.flush_i;
  assign long_inc = accept && bus.issue_long_i;
  assign long_dec = bus.long_done_i && (long_cnt != '0);

  // Clear first, then set, so a same-register set and clear leaves the bit set.
  always_comb begin
    pend_next = pend;
    if (bus.long_done_i) begin
      pend_next[bus.long_rd_i] = 1'b0;
    end
    if (accept && bus.issue_long_i && bus.issue_we_i && (bus.issue_rd_i != 5'd0)) begin
      pend_next[bus.issue_rd_i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend         <= '0;
      long_cnt     <= '0;
      stall_cycles <= '0;
      err          <= 1'b0;
    end else begin
      pend <= pend_next;
      case ({long_inc, long_dec})
        2'b10:   long_cnt <= long_cnt + CW'(1);
        2'b01:   long_cnt <= long_cnt - CW'(1);
        default: long_cnt <= long_cnt;
      endcase
      if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (bus.long_done_i && (long_cnt == '0)) begin
        err <= 1'b1;
      end
    end
  end

  assign bus.stall_o        = stall;
  assign bus.pend_o         = pend;
  assign bus.long_cnt_o     = long_cnt;
  assign bus.stall_cycles_o = stall_cycles;
  assign bus.err_o          = err;

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Directed-vector bench for fwd_hazard_scoreboard with hand-computed expectations.
`timescale 1ns/1ps
module tb_fwd_hazard_scoreboard;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors     = 0;
  int   miscompares = 0;

  fwd_hazard_scoreboard_if bus ();

  fwd_hazard_scoreboard dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] s0, input logic u0,
                               input logic [4:0] s1, input logic u1,
                               input logic [4:0] r0, input logic w0, input logic y0,
                               input logic [4:0] r1, input logic w1, input logic y1);
    bus.src_addr_i[0] = s0;  bus.src_used_i[0] = u0;
    bus.src_addr_i[1] = s1;  bus.src_used_i[1] = u1;
    bus.stg_rd_i[0]   = r0;  bus.stg_we_i[0]   = w0;  bus.stg_rdy_i[0] = y0;
    bus.stg_rd_i[1]   = r1;  bus.stg_we_i[1]   = w1;  bus.stg_rdy_i[1] = y1;
  endtask

  task automatic setIssue(input logic v, input logic [4:0] rd, input logic we,
                          input logic lng, input logic fl);
    bus.issue_valid_i = v;
    bus.issue_rd_i    = rd;
    bus.issue_we_i    = we;
    bus.issue_long_i  = lng;
    bus.flush_i       = fl;
  endtask

  task automatic setDone(input logic d, input logic [4:0] rd);
    bus.long_done_i = d;
    bus.long_rd_i   = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    setIssue(0, 0, 0, 0, 0);
    setDone(0, 0);
    #2;
    checkOutput("rst_pend",   bus.pend_o,         32'h0);
    checkOutput("rst_cnt",    bus.long_cnt_o,     32'h0);
    checkOutput("rst_cycles", bus.stall_cycles_o, 32'h0);
    checkOutput("rst_err",    bus.err_o,          32'h0);
    checkOutput("rst_sel0",   bus.fwd_sel_o[0],   32'h0);
    checkOutput("rst_sel1",   bus.fwd_sel_o[1],   32'h0);
    checkOutput("rst_stall",  bus.stall_o,        32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Youngest ready stage wins over an older ready one
    applyStimulus(5, 1, 0, 0, 5, 1, 1, 5, 1, 1);
    setIssue(1, 0, 0, 0, 0);
    #1;
    checkOutput("fwd_stage0_sel",   bus.fwd_sel_o[0], 32'd1);
    checkOutput("fwd_stage0_stall", bus.stall_o,      32'd0);
    checkOutput("fwd_unused_sel1",  bus.fwd_sel_o[1], 32'd0);

    // Load-use, then the load reaches stage1 ready
    applyStimulus(0, 0, 7, 1, 7, 1, 0, 0, 0, 0);
    #1;
    checkOutput("loaduse_stall", bus.stall_o, 32'd1);
    tick();
    checkOutput("loaduse_cycles", bus.stall_cycles_o, 32'd1);
    applyStimulus(0, 0, 7, 1, 0, 0, 0, 7, 1, 1);
    #1;
    checkOutput("load_fwd_sel",   bus.fwd_sel_o[1], 32'd2);
    checkOutput("load_fwd_stall", bus.stall_o,      32'd0);
    tick();
    applyStimulus(0, 0, 7, 1, 7, 1, 0, 7, 1, 1);
    #1;
    checkOutput("young_unready_stall", bus.stall_o, 32'd1);
    tick();
    checkOutput("cycles_after_load", bus.stall_cycles_o, 32'd2);

    // Long op to x9: RAW, WAW, then completion forwarding
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    setIssue(1, 9, 1, 1, 0);
    #1;
    checkOutput("long9_issue_stall", bus.stall_o, 32'd0);
    tick();
    checkOutput("long9_pend", bus.pend_o,     32'h0000_0200);
    checkOutput("long9_cnt",  bus.long_cnt_o, 32'd1);
    setIssue(0, 0, 0, 0, 0);
    applyStimulus(9, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("raw_no_valid_stall", bus.stall_o, 32'd0);
    setIssue(1, 0, 0, 0, 0);
    #1;
    checkOutput("raw_stall", bus.stall_o, 32'd1);
    tick();
    checkOutput("raw_cycles", bus.stall_cycles_o, 32'd3);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    setIssue(1, 9, 1, 0, 0);
    #1;
    checkOutput("waw_stall", bus.stall_o, 32'd1);
    tick();
    applyStimulus(9, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    setDone(1, 9);
    #1;
    checkOutput("done9_sel",   bus.fwd_sel_o[0], 32'd3);
    checkOutput("done9_stall", bus.stall_o,      32'd0);
    tick();
    setDone(0, 0);
    checkOutput("done9_pend",   bus.pend_o,         32'h0);
    checkOutput("done9_cnt",    bus.long_cnt_o,     32'd0);
    checkOutput("done9_cycles", bus.stall_cycles_o, 32'd4);

    // Fill to capacity, then overflow attempt
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      setIssue(1, 5'(i), 1, 1, 0);
      tick();
    end
    checkOutput("full_cnt",  bus.long_cnt_o, 32'd4);
    checkOutput("full_pend", bus.pend_o,     32'h0000_001E);
    setIssue(1, 5, 1, 1, 0);
    #1;
    checkOutput("cap_stall", bus.stall_o, 32'd1);
    tick();
    checkOutput("cap_cnt",    bus.long_cnt_o,     32'd4);
    checkOutput("cap_cycles", bus.stall_cycles_o, 32'd5);
    setDone(1, 1);
    #1;
    checkOutput("cap_done_stall", bus.stall_o, 32'd0);
    tick();
    checkOutput("cap_done_cnt",  bus.long_cnt_o, 32'd4);
    checkOutput("cap_done_pend", bus.pend_o,     32'h0000_003C);
    setIssue(1, 2, 1, 1, 0);
    setDone(1, 2);
    #1;
    checkOutput("setclr_stall", bus.stall_o, 32'd0);
    tick();
    checkOutput("setclr_cnt",  bus.long_cnt_o, 32'd4);
    checkOutput("setclr_pend", bus.pend_o,     32'h0000_003C);

    // Drain all four
    setIssue(0, 0, 0, 0, 0);
    for (int r = 2; r <= 5; r++) begin
      setDone(1, 5'(r));
      tick();
    end
    setDone(0, 0);
    checkOutput("drain_cnt",  bus.long_cnt_o, 32'd0);
    checkOutput("drain_pend", bus.pend_o,     32'h0);

    // Flushed long issue has no effect; x0 destinations and sources are inert
    setIssue(1, 6, 1, 1, 1);
    tick();
    checkOutput("flush_pend", bus.pend_o,     32'h0);
    checkOutput("flush_cnt",  bus.long_cnt_o, 32'd0);
    setIssue(1, 0, 1, 1, 0);
    applyStimulus(0, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    #1;
    checkOutput("x0_sel",   bus.fwd_sel_o[0], 32'd0);
    checkOutput("x0_stall", bus.stall_o,      32'd0);
    tick();
    checkOutput("x0_pend", bus.pend_o,     32'h0);
    checkOutput("x0_cnt",  bus.long_cnt_o, 32'd1);
    setIssue(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    setDone(1, 0);
    tick();
    setDone(0, 0);
    checkOutput("x0_done_cnt", bus.long_cnt_o, 32'd0);
    checkOutput("x0_done_err", bus.err_o,      32'd0);

    // Spurious completion sets the sticky error
    setDone(1, 3);
    tick();
    setDone(0, 0);
    checkOutput("err_set",   bus.err_o,      32'd1);
    checkOutput("err_cnt",   bus.long_cnt_o, 32'd0);
    tick();
    checkOutput("err_sticky",   bus.err_o,          32'd1);
    checkOutput("final_cycles", bus.stall_cycles_o, 32'd5);

    // Asynchronous reset mid-operation
    setIssue(1, 8, 1, 1, 0);
    tick();
    checkOutput("pre_rst_pend", bus.pend_o, 32'h0000_0100);
    setIssue(0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_pend",   bus.pend_o,         32'h0);
    checkOutput("mid_rst_cnt",    bus.long_cnt_o,     32'd0);
    checkOutput("mid_rst_cycles", bus.stall_cycles_o, 32'd0);
    checkOutput("mid_rst_err",    bus.err_o,          32'd0);
    checkOutput("mid_rst_stall",  bus.stall_o,        32'd0);
    checkOutput("mid_rst_sel0",   bus.fwd_sel_o[0],   32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
